sma_threshold_detector: RTL and testbench

Downstream consumer of the SMA filter output that turns the smoothed sample stream into discrete threshold-crossing events. It applies two-threshold hysteresis with a consecutive-sample debounce to the filtered signal, one sample per clock. For each qualified excursion it captures the peak value and the duration. Events are delivered over a valid/ready port with a single holding register and a saturating drop counter.

---
 rtl/sma_threshold_detector.sv | 176 +++++++++++++++++
 tb/tb_sma_threshold_detector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sma_threshold_detector.sv
// Hysteresis/debounce threshold-crossing detector on the SMA filter output.
// Captures peak and length per excursion and emits it through a one-deep valid/ready holding register.
module sma_threshold_detector #(
   parameter int DEBOUNCE = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] y,
   input  logic signed [15:0] th_hi,
   input  logic signed [15:0] th_lo,
   input  logic               ev_ready,
   output logic               ev_valid,
   output logic signed [15:0] ev_peak,
   output logic        [15:0] ev_len,
   output logic               active,
   output logic        [7:0]  drop_cnt
);

   localparam logic [7:0] DEB_C = 8'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_BELOW   = 2'd0,
      ST_RISING  = 2'd1,
      ST_ABOVE   = 2'd2,
      ST_FALLING = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic signed [15:0] pk_q, pk_d;
   logic [15:0]        ln_q, ln_d;
   logic               ev_valid_q, ev_valid_d;
   logic signed [15:0] ev_peak_q, ev_peak_d;
   logic [15:0]        ev_len_q, ev_len_d;
   logic               active_q, active_d;
   logic [7:0]         drop_q, drop_d;

   logic               hi_s, lo_s, emit_s;
   logic signed [15:0] pk_upd_s;
   logic [15:0]        ln_upd_s;
   logic [7:0]         cnt_inc_s;

   assign hi_s      = (y > th_hi);
   assign lo_s      = (y < th_lo);
   assign pk_upd_s  = (y > pk_q) ? y : pk_q;
   assign ln_upd_s  = (ln_q == 16'hFFFF) ? ln_q : (ln_q + 16'd1);
   assign cnt_inc_s = cnt_q + 8'd1;

   // Excursion FSM: state, debounce counter and peak/length accumulation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pk_d    = pk_q;
      ln_d    = ln_q;
      emit_s  = 1'b0;
      case (state_q)
         ST_BELOW: begin
            if (hi_s) begin
               cnt_d   = 8'd1;
               pk_d    = y;
               ln_d    = 16'd1;
               state_d = (DEB_C == 8'd1) ? ST_ABOVE : ST_RISING;
            end else begin
               state_d = ST_BELOW;
            end
         end
         ST_RISING: begin
            pk_d = pk_upd_s;
            ln_d = ln_upd_s;
            if (hi_s) begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == DEB_C) begin
                  state_d = ST_ABOVE;
               end else begin
                  state_d = ST_RISING;
               end
            end else begin
               cnt_d   = 8'd0;
               state_d = ST_BELOW;
            end
         end
         ST_ABOVE: begin
            pk_d = pk_upd_s;
            ln_d = ln_upd_s;
            if (lo_s) begin
               if (DEB_C == 8'd1) begin
                  emit_s  = 1'b1;
                  cnt_d   = 8'd0;
                  state_d = ST_BELOW;
               end else begin
                  cnt_d   = 8'd1;
                  state_d = ST_FALLING;
               end
            end else begin
               state_d = ST_ABOVE;
            end
         end
         ST_FALLING: begin
            pk_d = pk_upd_s;
            ln_d = ln_upd_s;
            if (lo_s) begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == DEB_C) begin
                  emit_s  = 1'b1;
                  cnt_d   = 8'd0;
                  state_d = ST_BELOW;
               end else begin
                  state_d = ST_FALLING;
               end
            end else begin
               // Bounce back above th_lo restarts the falling debounce
               cnt_d   = 8'd0;
               state_d = ST_ABOVE;
            end
         end
         default: begin
            cnt_d   = 8'd0;
            state_d = ST_BELOW;
         end
      endcase
   end

   // Holding register: load on emit when empty or being drained, otherwise count a drop
   always_comb begin
      ev_valid_d = ev_valid_q;
      ev_peak_d  = ev_peak_q;
      ev_len_d   = ev_len_q;
      drop_d     = drop_q;
      active_d   = (state_d == ST_ABOVE) || (state_d == ST_FALLING);
      if (emit_s) begin
         if (!ev_valid_q || ev_ready) begin
            ev_valid_d = 1'b1;
            ev_peak_d  = pk_d;
            ev_len_d   = ln_d;
         end else begin
            drop_d = (drop_q == 8'hFF) ? drop_q : (drop_q + 8'd1);
         end
      end else if (ev_valid_q && ev_ready) begin
         ev_valid_d = 1'b0;
      end else begin
         ev_valid_d = ev_valid_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_BELOW;
         cnt_q      <= 8'd0;
         pk_q       <= 16'sd0;
         ln_q       <= 16'd0;
         ev_valid_q <= 1'b0;
         ev_peak_q  <= 16'sd0;
         ev_len_q   <= 16'd0;
         active_q   <= 1'b0;
         drop_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pk_q       <= pk_d;
         ln_q       <= ln_d;
         ev_valid_q <= ev_valid_d;
         ev_peak_q  <= ev_peak_d;
         ev_len_q   <= ev_len_d;
         active_q   <= active_d;
         drop_q     <= drop_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_peak  = ev_peak_q;
   assign ev_len   = ev_len_q;
   assign active   = active_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sma_threshold_detector.sv
// Directed bench for sma_threshold_detector: per-cycle vector table plus hand sequences
// for backpressure, length saturation and mid-excursion reset.
module tb_sma_threshold_detector;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic signed [15:0] y = 16'sd0;
   logic signed [15:0] th_hi = 16'sd1000;
   logic signed [15:0] th_lo = 16'sd500;
   logic               ev_ready = 1'b1;
   logic               ev_valid;
   logic signed [15:0] ev_peak;
   logic        [15:0] ev_len;
   logic               active;
   logic        [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   sma_threshold_detector #(.DEBOUNCE(4)) dut (
      .clk(clk), .rst(rst), .y(y), .th_hi(th_hi), .th_lo(th_lo),
      .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_peak(ev_peak),
      .ev_len(ev_len), .active(active), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [15:0] y;
      logic               rdy;
      logic               v;
      logic               a;
      logic signed [15:0] pk;
      logic [15:0]        ln;
      logic [7:0]         dr;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic signed [15:0] yy, input logic rr, input logic vv,
                               input logic aa, input logic signed [15:0] pp,
                               input logic [15:0] ll, input logic [7:0] dd);
      vec_t e;
      e.y = yy; e.rdy = rr; e.v = vv; e.a = aa; e.pk = pp; e.ln = ll; e.dr = dd;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic a,
                          input logic signed [15:0] pk, input logic [15:0] ln, input logic [7:0] dr);
      chk({tag, ".ev_valid"}, {31'd0, ev_valid}, {31'd0, v});
      chk({tag, ".active"},   {31'd0, active},   {31'd0, a});
      chk({tag, ".ev_peak"},  {16'd0, ev_peak},  {16'd0, pk});
      chk({tag, ".ev_len"},   {16'd0, ev_len},   {16'd0, ln});
      chk({tag, ".drop_cnt"}, {24'd0, drop_cnt}, {24'd0, dr});
   endtask

   task automatic step(input logic signed [15:0] yy, input logic rr);
      @(negedge clk);
      y = yy;
      ev_ready = rr;
      @(posedge clk);
      #1;
   endtask

   // One complete excursion of length 9 with the given peak; held payload checked on the way
   task automatic exc(input logic signed [15:0] pk, input logic last_rdy, input logic signed [15:0] hold_pk);
      for (int i = 0; i < 4; i++) begin
         step(16'sd1200, 1'b0);
         chk("bp_hold_rise", {16'd0, ev_peak}, {16'd0, hold_pk});
      end
      step(pk, 1'b0);
      chk("bp_hold_peak", {16'd0, ev_peak}, {16'd0, hold_pk});
      for (int i = 0; i < 3; i++) begin
         step(16'sd100, 1'b0);
         chk("bp_hold_fall", {16'd0, ev_peak}, {16'd0, hold_pk});
      end
      step(16'sd100, last_rdy);
   endtask

   initial begin
      // Glitch rejection: three samples above th_hi never qualify
      for (int i = 0; i < 3; i++) add(16'sd2000, 1'b1, 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      add(16'sd0, 1'b1, 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      // Basic event: peak 3500, length 14
      for (int i = 0; i < 3; i++) add(16'sd1200, 1'b1, 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      add(16'sd1200, 1'b1, 1'b0, 1'b1, 16'sd0, 16'd0, 8'd0);
      add(16'sd3500, 1'b1, 1'b0, 1'b1, 16'sd0, 16'd0, 8'd0);
      for (int i = 0; i < 5; i++) add(16'sd1200, 1'b1, 1'b0, 1'b1, 16'sd0, 16'd0, 8'd0);
      for (int i = 0; i < 3; i++) add(16'sd100, 1'b1, 1'b0, 1'b1, 16'sd0, 16'd0, 8'd0);
      add(16'sd100, 1'b1, 1'b1, 1'b0, 16'sd3500, 16'd14, 8'd0);
      add(16'sd0, 1'b1, 1'b0, 1'b0, 16'sd3500, 16'd14, 8'd0);
      // Hysteresis bounce: one event, peak 1200, length 12
      for (int i = 0; i < 3; i++) add(16'sd1200, 1'b1, 1'b0, 1'b0, 16'sd3500, 16'd14, 8'd0);
      add(16'sd1200, 1'b1, 1'b0, 1'b1, 16'sd3500, 16'd14, 8'd0);
      for (int i = 0; i < 3; i++) add(16'sd400, 1'b1, 1'b0, 1'b1, 16'sd3500, 16'd14, 8'd0);
      add(16'sd600, 1'b1, 1'b0, 1'b1, 16'sd3500, 16'd14, 8'd0);
      for (int i = 0; i < 3; i++) add(16'sd400, 1'b1, 1'b0, 1'b1, 16'sd3500, 16'd14, 8'd0);
      add(16'sd400, 1'b1, 1'b1, 1'b0, 16'sd1200, 16'd12, 8'd0);
      add(16'sd0, 1'b1, 1'b0, 1'b0, 16'sd1200, 16'd12, 8'd0);

      // Reset held with random input
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         y = 16'($urandom);
         @(posedge clk);
         #1;
         chk_all("reset", 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      y = 16'sd0;
      for (int i = 0; i < 20; i++) begin
         step(16'sd0, 1'b1);
         chk_all("idle", 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].y, tbl[i].rdy);
         chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].a, tbl[i].pk, tbl[i].ln, tbl[i].dr);
      end

      // Backpressure: first event held, second dropped, third loaded on same-cycle accept
      exc(16'sd3000, 1'b0, 16'sd1200);
      chk_all("bp_first", 1'b1, 1'b0, 16'sd3000, 16'd9, 8'd0);
      step(16'sd0, 1'b0);
      exc(16'sd4000, 1'b0, 16'sd3000);
      chk_all("bp_drop", 1'b1, 1'b0, 16'sd3000, 16'd9, 8'd1);
      step(16'sd0, 1'b0);
      exc(16'sd5000, 1'b1, 16'sd3000);
      chk_all("bp_b2b", 1'b1, 1'b0, 16'sd5000, 16'd9, 8'd1);
      step(16'sd0, 1'b0);
      chk_all("bp_keep", 1'b1, 1'b0, 16'sd5000, 16'd9, 8'd1);
      step(16'sd0, 1'b1);
      chk_all("bp_accept", 1'b0, 1'b0, 16'sd5000, 16'd9, 8'd1);

      // Negative thresholds and length saturation
      @(negedge clk);
      th_hi = -16'sd100;
      th_lo = -16'sd200;
      y = -16'sd150;
      for (int i = 0; i < 70000; i++) step(-16'sd50, 1'b1);
      chk("sat_active", {31'd0, active}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(-16'sd300, 1'b1);
         chk_all("sat_fall", 1'b0, 1'b1, 16'sd5000, 16'd9, 8'd1);
      end
      step(-16'sd300, 1'b0);
      chk_all("sat_emit", 1'b1, 1'b0, -16'sd50, 16'hFFFF, 8'd1);

      // Reset during a later excursion with an event still pending
      for (int i = 0; i < 5; i++) step(-16'sd50, 1'b0);
      chk_all("pre_rst", 1'b1, 1'b1, -16'sd50, 16'hFFFF, 8'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst_hold", 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(-16'sd150, 1'b1);
         chk_all("post_rst", 1'b0, 1'b0, 16'sd0, 16'd0, 8'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
